// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame store: a ray renderer fills the back bank while the display scans the front bank upscaled 4x.
// Optional macro FB_DROP_COUNT_EN adds a saturating count of dropped writes on dropped_writes_out.
module frame_buffer_ctrl #(
  parameter int PIXEL_WIDTH        = 16,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720,
  parameter int SCREEN_WIDTH       = 320,
  parameter int SCREEN_HEIGHT      = 180
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic                   ray_valid_in,
  input  logic [15:0]            ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_pixel_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  output logic [1:0]             fb_ready_to_switch_out,
  output logic                   frame_swap_out,
  output logic [PIXEL_WIDTH-1:0] pixel_out
`ifdef FB_DROP_COUNT_EN
  ,
  output logic [15:0]            dropped_writes_out
`endif
);

  localparam int          DEPTH   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [10:0] FSW_L   = 11'(FULL_SCREEN_WIDTH);
  localparam logic [9:0]  FSH_L   = 10'(FULL_SCREEN_HEIGHT);

  typedef enum logic {WRITING, WAIT_SWAP} state_t;

  state_t state_q, state_d;
  logic   front_sel_q, front_sel_d;
  logic [1:0] ready_q, ready_d;
  logic   swap_q, swap_d;
  logic   wr_en;
  logic   in_range;

  logic [PIXEL_WIDTH-1:0] bank0_mem [DEPTH];
  logic [PIXEL_WIDTH-1:0] bank1_mem [DEPTH];

  logic [16:0]            rd_addr_full;
  logic [15:0]            rd_addr_d, rd_addr_q;
  logic                   rd_blank_d, rd_blank_q;
  logic                   rd_bank_q;
  logic [PIXEL_WIDTH-1:0] pixel_q;

  assign in_range = {1'b0, ray_address_in} < DEPTH_L;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    front_sel_d = front_sel_q;
    ready_d     = {vcount_in >= FSH_L, ready_q[0]};
    swap_d      = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      WRITING: begin
        if (ray_valid_in) begin
          wr_en = in_range;
          if (ray_last_pixel_in) begin
            ready_d[0] = 1'b1;
            state_d    = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (ready_q == 2'b11) begin
          front_sel_d = ~front_sel_q;
          swap_d      = 1'b1;
          ready_d[0]  = 1'b0;
          state_d     = WRITING;
        end
      end
      default: state_d = WRITING;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= WRITING;
      front_sel_q <= 1'b0;
      ready_q     <= 2'b00;
      swap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      ready_q     <= ready_d;
      swap_q      <= swap_d;
    end
  end

  // NOTE: the banks have no reset; a frame survives reset and RAM inference stays possible.
  always_ff @(posedge pixel_clk_in) begin
    if (wr_en && rst_in) begin
      if (front_sel_q) bank0_mem[ray_address_in] <= ray_pixel_in;
      else             bank1_mem[ray_address_in] <= ray_pixel_in;
    end
  end

  assign rd_addr_full = 17'(vcount_in >> 2) * 17'(SCREEN_WIDTH) + 17'(hcount_in >> 2);
  assign rd_blank_d   = (hcount_in >= FSW_L) || (vcount_in >= FSH_L);
  assign rd_addr_d    = rd_blank_d ? 16'd0 : 16'(rd_addr_full);

  // The bank is captured with the address so a swap only affects reads issued after it.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_addr_q  <= '0;
      rd_blank_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      pixel_q    <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_blank_q <= rd_blank_d;
      rd_bank_q  <= front_sel_q;
      if (rd_blank_q)     pixel_q <= '0;
      else if (rd_bank_q) pixel_q <= bank1_mem[rd_addr_q];
      else                pixel_q <= bank0_mem[rd_addr_q];
    end
  end

`ifdef FB_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = ray_valid_in && ((state_q == WAIT_SWAP) || !in_range);

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in)                            drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign dropped_writes_out = drop_cnt_q;
`endif

  assign fb_ready_to_switch_out = ready_q;
  assign frame_swap_out         = swap_q;
  assign pixel_out              = pixel_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl: reset, full fill and swap, readback tables, bounds and back-to-back writes.
module tb_frame_buffer_ctrl;

  localparam int DEPTH = 57600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] addr;
  logic [15:0] pix;
  logic        last;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [1:0]  ready;
  logic        swap;
  logic [15:0] pixel;
`ifdef FB_DROP_COUNT_EN
  logic [15:0] dropped;
`endif

  always #5 clk = ~clk;

  frame_buffer_ctrl dut (
    .pixel_clk_in          (clk),
    .rst_in                (rst_n),
    .ray_valid_in          (valid),
    .ray_address_in        (addr),
    .ray_pixel_in          (pix),
    .ray_last_pixel_in     (last),
    .hcount_in             (hcount),
    .vcount_in             (vcount),
    .fb_ready_to_switch_out(ready),
    .frame_swap_out        (swap),
    .pixel_out             (pixel)
`ifdef FB_DROP_COUNT_EN
    ,
    .dropped_writes_out    (dropped)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          phase;
    logic [10:0] h;
    logic [9:0]  v;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int a);
    if (a == 321) return 16'h1234;
    return 16'(a) ^ 16'h5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] p, input logic l);
    valid = 1'b1;
    addr  = a;
    pix   = p;
    last  = l;
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic apply_tbl(input int phase);
    foreach (tbl[i]) begin
      if (tbl[i].phase == phase) begin
        hcount = tbl[i].h;
        vcount = tbl[i].v;
        tick();
        tick();
        check($sformatf("read p%0d h=%0d v=%0d", phase, tbl[i].h, tbl[i].v), 32'(pixel), 32'(tbl[i].exp));
      end
    end
  endtask

  function automatic rd_vec_t mk(input int ph, input int h, input int v, input logic [15:0] e);
    rd_vec_t r;
    r.phase = ph;
    r.h     = 11'(h);
    r.v     = 10'(v);
    r.exp   = e;
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase 1: first full frame (bank 1) displayed after the first swap.
    tbl.push_back(mk(1, 4, 4, 16'h1234));
    tbl.push_back(mk(1, 7, 7, 16'h1234));
    tbl.push_back(mk(1, 5, 6, 16'h1234));
    tbl.push_back(mk(1, 0, 0, pat(0)));
    tbl.push_back(mk(1, 8, 4, pat(322)));
    tbl.push_back(mk(1, 3, 4, pat(320)));
    tbl.push_back(mk(1, 1279, 719, pat(57599)));
    tbl.push_back(mk(1, 1280, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 720, 16'h0000));
    tbl.push_back(mk(1, 2047, 1023, 16'h0000));
    // Phase 2: sparse frame written into bank 0.
    tbl.push_back(mk(2, 0, 0, 16'h1111));
    tbl.push_back(mk(2, 6, 5, 16'h2222));
    tbl.push_back(mk(2, 1279, 719, 16'h4444));
    // Phase 3: bank 1 again, holding the back-to-back write and the old frame.
    tbl.push_back(mk(3, 0, 0, 16'h5555));
    tbl.push_back(mk(3, 4, 4, 16'h1234));
    tbl.push_back(mk(3, 400, 0, 16'h6666));
    tbl.push_back(mk(3, 8, 4, pat(322)));

    rst_n  = 1'b0;
    valid  = 1'b0;
    addr   = '0;
    pix    = '0;
    last   = 1'b0;
    hcount = '0;
    vcount = 10'd100;
    repeat (3) tick();
    check("reset ready", 32'(ready), 32'd0);
    check("reset swap", 32'(swap), 32'd0);
    check("reset pixel", 32'(pixel), 32'd0);
`ifdef FB_DROP_COUNT_EN
    check("reset dropped", 32'(dropped), 32'd0);
`endif

    // Reset asserted mid-frame, with a write in flight, abandons the frame.
    rst_n = 1'b1;
    tick();
    wr(16'd0, 16'hBEEF, 1'b1);
    check("pre-reset last sets bit0", 32'(ready), 32'd1);
    valid = 1'b1;
    addr  = 16'd5;
    pix   = 16'hDEAD;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset ready", 32'(ready), 32'd0);
    check("async reset swap", 32'(swap), 32'd0);
    check("async reset pixel", 32'(pixel), 32'd0);
    tick();
    valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("post-reset ready", 32'(ready), 32'd0);

    // Full fill of bank 1 with the last pixel flagged.
    for (int a = 0; a < DEPTH; a++) wr(16'(a), pat(a), a == DEPTH - 1);
    check("fill done ready", 32'(ready), 32'd1);
    repeat (5) begin
      tick();
      check("no swap in active video", 32'(swap), 32'd0);
    end
    check("hold ready", 32'(ready), 32'd1);

    // Writes while waiting for the swap are all dropped.
    for (int i = 0; i < 10; i++) wr((i % 2) ? 16'd321 : 16'd0, 16'hFFFF, 1'b0);
    check("wait_swap ready", 32'(ready), 32'd1);
`ifdef FB_DROP_COUNT_EN
    check("dropped after wait_swap", 32'(dropped), 32'd10);
`endif

    vcount = 10'd720;
    tick();
    check("vblank ready", 32'(ready), 32'd3);
    check("vblank no swap yet", 32'(swap), 32'd0);
    tick();
    check("swap pulse", 32'(swap), 32'd1);
    check("swap clears bit0", 32'(ready), 32'd2);
    tick();
    check("swap single cycle", 32'(swap), 32'd0);
    apply_tbl(1);

    // Second frame into bank 0, including an out-of-range and an unqualified last.
    hcount = '0;
    vcount = 10'd100;
    tick();
    last = 1'b1;
    tick();
    last = 1'b0;
    check("last without valid ignored", 32'(ready), 32'd0);
    wr(16'd0, 16'h1111, 1'b0);
    wr(16'd321, 16'h2222, 1'b0);
    wr(16'd57600, 16'h3333, 1'b0);
    check("out-of-range no ready", 32'(ready), 32'd0);
`ifdef FB_DROP_COUNT_EN
    check("dropped out-of-range", 32'(dropped), 32'd11);
`endif
    wr(16'd57599, 16'h4444, 1'b1);
    check("frame2 ready", 32'(ready), 32'd1);
    vcount = 10'd720;
    tick();
    check("frame2 vblank ready", 32'(ready), 32'd3);
    tick();
    check("frame2 swap", 32'(swap), 32'd1);
    wr(16'd0, 16'h5555, 1'b0);
    check("back-to-back ready", 32'(ready), 32'd2);
    apply_tbl(2);

    // Third frame: a swap only affects reads whose address is loaded after it.
    vcount = 10'd100;
    wr(16'd100, 16'h6666, 1'b1);
    check("frame3 ready", 32'(ready), 32'd1);
    vcount = 10'd720;
    tick();
    check("frame3 vblank ready", 32'(ready), 32'd3);
    hcount = '0;
    vcount = '0;
    tick();
    check("frame3 swap", 32'(swap), 32'd1);
    tick();
    check("read issued at swap edge sees old bank", 32'(pixel), 32'h1111);
    tick();
    check("read after swap sees new bank", 32'(pixel), 32'h5555);
    apply_tbl(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
